// File: rtl/gpu_pkg.sv
// -----------------------------------------------------------------------------
// gpu_pkg
// Shared constants and types for the rasterizer frame path: default screen
// geometry, framebuffer widths, the packed vertex / triangle-command layout and
// the frame sequencer state encoding.
// -----------------------------------------------------------------------------
package gpu_pkg;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int FB_PIXELS = H_RES * V_RES;
  localparam int ADDR_W    = 19;
  localparam int COLOR_W   = 6;
  localparam int CMD_DEPTH = 4;

  localparam int VERT_W = 20;
  localparam int CMD_W  = 3 * VERT_W + 1;

  // Vertex as carried on the command and rasterizer buses: {x[19:10], y[9:0]}.
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } vertex_t;

  // One queued triangle; field order fixes the FIFO entry layout.
  typedef struct packed {
    vertex_t v0;
    vertex_t v1;
    vertex_t v2;
    logic    last;
  } tri_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    RSTART,
    RWAIT,
    FDONE
  } seq_state_t;

endpackage

// File: rtl/frame_sequencer_cmd_fifo.sv
// -----------------------------------------------------------------------------
// cmd_fifo
// Synchronous FIFO for triangle commands. Registered pointers with one extra
// wrap bit distinguish full from empty. When full, a push in the same cycle
// as a pop is still accepted.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (pointers only)
//   i_push, i_wdata   write request and data
//   i_pop             read request; o_rdata is the current head (show-ahead)
//   o_full, o_empty   occupancy flags
// -----------------------------------------------------------------------------
module cmd_fifo #(
  parameter int WIDTH = 61,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours, matching real hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; resetting the pointers already
  // makes every entry invalid, and an unreset array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
// Per-frame controller for the triangle rasterizer. A frame request clears the
// framebuffer to a background colour, then queued triangles are handed to the
// rasterizer one at a time. The rasterizer is held in reset between triangles
// so its sticky done flag re-arms. The single framebuffer write port is shared
// between the clear engine and the rasterizer.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   frame_start, bg_color       frame request and clear colour (sampled in IDLE)
//   cmd_valid/cmd_ready         triangle command handshake
//   cmd_v0..2, cmd_last         triangle vertices {x,y} and end-of-frame mark
//   rast_reset, rast_start      rasterizer sync reset (high) and start pulse
//   rast_done                   rasterizer done (sticky until rast_reset)
//   rast_v0..2                  vertices presented to the rasterizer
//   rast_addr/dout/wen          rasterizer framebuffer write request
//   fb_addr/dout/wen            framebuffer write port
//   busy, frame_done            not-idle flag, one-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
module frame_sequencer
  import gpu_pkg::*;
#(
  parameter int H_RES     = gpu_pkg::H_RES,
  parameter int V_RES     = gpu_pkg::V_RES,
  parameter int ADDR_W    = gpu_pkg::ADDR_W,
  parameter int COLOR_W   = gpu_pkg::COLOR_W,
  parameter int CMD_DEPTH = gpu_pkg::CMD_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [COLOR_W-1:0] bg_color,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [19:0]        cmd_v0,
  input  logic [19:0]        cmd_v1,
  input  logic [19:0]        cmd_v2,
  input  logic               cmd_last,
  output logic               rast_reset,
  output logic               rast_start,
  input  logic               rast_done,
  output logic [19:0]        rast_v0,
  output logic [19:0]        rast_v1,
  output logic [19:0]        rast_v2,
  input  logic [ADDR_W-1:0]  rast_addr,
  input  logic [COLOR_W-1:0] rast_dout,
  input  logic               rast_wen,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_dout,
  output logic               fb_wen,
  output logic               busy,
  output logic               frame_done
);

  localparam int N_PIXELS = H_RES * V_RES;

  seq_state_t         r_state;
  seq_state_t         w_next;
  logic [ADDR_W-1:0]  r_clr_cnt;
  logic [COLOR_W-1:0] r_bg;
  vertex_t            r_v0;
  vertex_t            r_v1;
  vertex_t            r_v2;
  logic               r_last_q;

  tri_cmd_t           w_push_cmd;
  tri_cmd_t           w_pop_cmd;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_clr_last;

  // ---------------------------------------------------------------------------
  // Command queue: accepts in every state, drained only from FETCH.
  // ---------------------------------------------------------------------------
  assign w_push_cmd = {cmd_v0, cmd_v1, cmd_v2, cmd_last};
  assign cmd_ready  = !w_full;
  assign w_push     = cmd_valid && cmd_ready;
  assign w_pop      = (r_state == FETCH) && !w_empty;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_wdata (w_push_cmd),
    .i_pop   (w_pop),
    .o_rdata (w_pop_cmd),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Terminal compare at full 32-bit width so the pixel count never aliases
  // against a narrower counter.
  assign w_clr_last = (32'(r_clr_cnt) == 32'(N_PIXELS - 1));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next     = r_state;
    fb_wen     = 1'b0;
    fb_addr    = '0;
    fb_dout    = '0;
    rast_reset = 1'b1;
    rast_start = 1'b0;
    frame_done = 1'b0;
    busy       = (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (frame_start) w_next = CLEAR;
      end
      CLEAR: begin
        fb_wen  = 1'b1;
        fb_addr = r_clr_cnt;
        fb_dout = r_bg;
        if (w_clr_last) w_next = FETCH;
      end
      FETCH: begin
        if (!w_empty) w_next = RSTART;
      end
      RSTART: begin
        // rast_done may still be stale here; it is not looked at.
        rast_reset = 1'b0;
        rast_start = 1'b1;
        w_next     = RWAIT;
      end
      RWAIT: begin
        rast_reset = 1'b0;
        fb_wen     = rast_wen;
        fb_addr    = rast_addr;
        fb_dout    = rast_dout;
        if (rast_done) w_next = r_last_q ? FDONE : FETCH;
      end
      FDONE: begin
        frame_done = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: clear counter, latched colour, current triangle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clr_cnt <= '0;
      r_bg      <= '0;
      r_v0      <= '0;
      r_v1      <= '0;
      r_v2      <= '0;
      r_last_q  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_bg      <= bg_color;
            r_clr_cnt <= '0;
          end
        end
        CLEAR: r_clr_cnt <= r_clr_cnt + 1'b1;
        FETCH: begin
          if (w_pop) begin
            r_v0     <= w_pop_cmd.v0;
            r_v1     <= w_pop_cmd.v1;
            r_v2     <= w_pop_cmd.v2;
            r_last_q <= w_pop_cmd.last;
          end
        end
        default: ;
      endcase
    end
  end

  assign rast_v0 = r_v0;
  assign rast_v1 = r_v1;
  assign rast_v2 = r_v2;

endmodule

// File: tb/tb_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_sequencer
// Scoreboard bench for frame_sequencer on an 8x4 screen. Stimulus tasks push
// expected framebuffer writes, rasterizer starts and frame-done events into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
// The rasterizer model raises a sticky done 10 cycles after start, writes
// three pixels derived from its vertices, and drives junk writes while held in
// reset so any leak onto the framebuffer port is caught.
// -----------------------------------------------------------------------------
module tb_frame_sequencer;

  localparam int H      = 8;
  localparam int V      = 4;
  localparam int NPIX   = H * V;
  localparam int AW     = 19;
  localparam int CW     = 6;
  localparam int N_DONE = 10;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
  } fbw_t;

  typedef struct packed {
    logic [19:0] v0;
    logic [19:0] v1;
    logic [19:0] v2;
  } tri_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_start = 1'b0;
  logic [CW-1:0] bg_color = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [19:0]   cmd_v0 = '0;
  logic [19:0]   cmd_v1 = '0;
  logic [19:0]   cmd_v2 = '0;
  logic          cmd_last = 1'b0;
  logic          rast_reset;
  logic          rast_start;
  logic          rast_done;
  logic [19:0]   rast_v0;
  logic [19:0]   rast_v1;
  logic [19:0]   rast_v2;
  logic [AW-1:0] rast_addr;
  logic [CW-1:0] rast_dout;
  logic          rast_wen;
  logic [AW-1:0] fb_addr;
  logic [CW-1:0] fb_dout;
  logic          fb_wen;
  logic          busy;
  logic          frame_done;

  int n_cmp  = 0;
  int n_fail = 0;

  fbw_t exp_fb[$];
  tri_t exp_start[$];
  bit   exp_done[$];

  frame_sequencer #(
    .H_RES     (H),
    .V_RES     (V),
    .ADDR_W    (AW),
    .COLOR_W   (CW),
    .CMD_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .bg_color    (bg_color),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_v0      (cmd_v0),
    .cmd_v1      (cmd_v1),
    .cmd_v2      (cmd_v2),
    .cmd_last    (cmd_last),
    .rast_reset  (rast_reset),
    .rast_start  (rast_start),
    .rast_done   (rast_done),
    .rast_v0     (rast_v0),
    .rast_v1     (rast_v1),
    .rast_v2     (rast_v2),
    .rast_addr   (rast_addr),
    .rast_dout   (rast_dout),
    .rast_wen    (rast_wen),
    .fb_addr     (fb_addr),
    .fb_dout     (fb_dout),
    .fb_wen      (fb_wen),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Rasterizer model. 'lazy' makes done clear only on the next start, which
  // leaves it stale-high through FETCH and RSTART.
  // ---------------------------------------------------------------------------
  logic          lazy = 1'b0;
  logic          m_active = 1'b0;
  logic          m_done = 1'b0;
  logic [3:0]    m_cnt = '0;
  logic [AW-1:0] m_base = '0;
  logic [CW-1:0] m_col = '0;

  always @(posedge clk) begin
    if (rast_start) begin
      m_active <= 1'b1;
      m_cnt    <= '0;
      m_done   <= 1'b0;
      m_base   <= rast_v0[AW-1:0];
      m_col    <= rast_v2[CW-1:0];
    end else if (rast_reset) begin
      m_active <= 1'b0;
      if (!lazy) m_done <= 1'b0;
    end else if (m_active && !m_done) begin
      m_cnt <= m_cnt + 1'b1;
      if (m_cnt == 4'(N_DONE - 1)) m_done <= 1'b1;
    end
  end

  assign rast_done = m_done;
  assign rast_wen  = rast_reset ? 1'b1 : (m_active && !m_done && (m_cnt < 4'd3));
  assign rast_addr = rast_reset ? '1 : m_base + AW'(m_cnt);
  assign rast_dout = rast_reset ? '1 : m_col;

  // ---------------------------------------------------------------------------
  // Check helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: DUT event with nothing expected (t=%0t)", name, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  logic p_rst = 1'b1;
  logic p_start = 1'b0;
  logic p_done_rwait = 1'b0;
  logic p_fdone = 1'b0;
  int   stale_seen = 0;
  tri_t last_tri = '0;

  always @(negedge clk) begin
    fbw_t e;
    tri_t t;
    if (fb_wen) begin
      if (exp_fb.size() == 0) unexpected("fb_write");
      else begin
        e = exp_fb.pop_front();
        check("fb_addr", fb_addr, e.addr);
        check("fb_dout", fb_dout, e.data);
      end
    end
    if (!rast_reset && !rast_start) begin
      check("pass_wen", fb_wen, rast_wen);
      if (rast_wen) begin
        check("pass_addr", fb_addr, rast_addr);
        check("pass_dout", fb_dout, rast_dout);
      end
    end
    if (rast_start) begin
      check("start_rast_reset_low", rast_reset, 1'b0);
      check("start_prev_rast_reset", p_rst, 1'b1);
      if (rast_done) stale_seen++;
      if (exp_start.size() == 0) unexpected("rast_start");
      else begin
        t = exp_start.pop_front();
        check("rast_v0", rast_v0, t.v0);
        check("rast_v1", rast_v1, t.v1);
        check("rast_v2", rast_v2, t.v2);
        last_tri = t;
      end
    end
    if (p_start) check("start_single_cycle", rast_start, 1'b0);
    if (frame_done) begin
      check("done_after_rast_done", p_done_rwait, 1'b1);
      check("rast_v0_held", rast_v0, last_tri.v0);
      if (exp_done.size() == 0) unexpected("frame_done");
      else void'(exp_done.pop_front());
    end
    if (p_fdone) begin
      check("idle_after_done", busy, 1'b0);
      check("done_single_cycle", frame_done, 1'b0);
    end
    p_rst        = rast_reset;
    p_start      = rast_start;
    p_done_rwait = !rast_reset && !rast_start && rast_done;
    p_fdone      = frame_done;
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks (inputs change 1ns after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic start_frame(input logic [CW-1:0] bg);
    @(posedge clk); #1;
    frame_start = 1'b1;
    bg_color    = bg;
    for (int i = 0; i < NPIX; i++) exp_fb.push_back(fbw_t'{addr: AW'(i), data: bg});
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic send_cmd(input logic [19:0] a, input logic [19:0] b, input logic [19:0] c,
                          input logic l, input bit run, output bit acc_start);
    bit rdy;
    bit acc;
    acc       = 1'b0;
    acc_start = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_v0    = a;
    cmd_v1    = b;
    cmd_v2    = c;
    cmd_last  = l;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      rdy       = cmd_ready;
      acc_start = rast_start;
      @(posedge clk);
      if (rdy) begin
        acc = 1'b1;
        break;
      end
    end
    #1 cmd_valid = 1'b0;
    check("cmd_accepted", acc, 1'b1);
    if (acc && run) begin
      exp_start.push_back(tri_t'{v0: a, v1: b, v2: c});
      for (int j = 0; j < 3; j++)
        exp_fb.push_back(fbw_t'{addr: a[AW-1:0] + AW'(j), data: c[CW-1:0]});
      if (l) exp_done.push_back(1'b1);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_idle_in_budget", ok, 1'b1);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_fb_queue"},    exp_fb.size(),    0);
    check({tag, "_start_queue"}, exp_start.size(), 0);
    check({tag, "_done_queue"},  exp_done.size(),  0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit acc;
    bit found;

    // 1. reset and idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_fb_wen", fb_wen, 1'b0);
      check("rst_rast_reset", rast_reset, 1'b1);
      check("rst_rast_start", rast_start, 1'b0);
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_fb_wen", fb_wen, 1'b0);
      check("idle_rast_reset", rast_reset, 1'b1);
      check("idle_rast_start", rast_start, 1'b0);
      check("idle_cmd_ready", cmd_ready, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_frame_done", frame_done, 1'b0);
    end

    // 2. clear with colour 3; a second request mid-clear is ignored
    start_frame(6'b000011);
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk);
      check("clr_wen", fb_wen, 1'b1);
      if (i == 5) begin
        check("clr_busy", busy, 1'b1);
        frame_start = 1'b1;
        bg_color    = 6'h2A;
      end
      if (i == 6) frame_start = 1'b0;
    end
    @(negedge clk);
    check("clr_len_end", fb_wen, 1'b0);
    check("clr_all_written", exp_fb.size(), 0);

    // 3. single triangle, last of frame
    send_cmd({10'd230, 10'd200}, {10'd400, 10'd450}, {10'd170, 10'd400}, 1'b1, 1'b1, acc);
    wait_idle(100);
    check_drained("t3");

    // 4. five pushes into a four-deep queue during clear
    start_frame(6'h15);
    send_cmd({10'd10, 10'd20}, {10'd30, 10'd40}, {10'd50, 10'd61}, 1'b0, 1'b1, acc);
    send_cmd({10'd11, 10'd21}, {10'd31, 10'd41}, {10'd51, 10'd62}, 1'b0, 1'b1, acc);
    send_cmd({10'd12, 10'd22}, {10'd32, 10'd42}, {10'd52, 10'd63}, 1'b0, 1'b1, acc);
    send_cmd({10'd13, 10'd23}, {10'd33, 10'd43}, {10'd53, 10'd64}, 1'b0, 1'b1, acc);
    @(negedge clk);
    check("full_cmd_ready", cmd_ready, 1'b0);
    check("full_still_clearing", fb_wen, 1'b1);
    send_cmd({10'd14, 10'd24}, {10'd34, 10'd44}, {10'd54, 10'd65}, 1'b1, 1'b1, acc);
    check("fifth_accepted_at_first_pop", acc, 1'b1);
    wait_idle(300);
    check_drained("t4");

    // 5. three triangles with stale done through FETCH/RSTART
    lazy       = 1'b1;
    stale_seen = 0;
    start_frame(6'h2C);
    send_cmd({10'd100, 10'd1}, {10'd101, 10'd2}, {10'd102, 10'd7}, 1'b0, 1'b1, acc);
    send_cmd({10'd200, 10'd3}, {10'd201, 10'd4}, {10'd202, 10'd9}, 1'b0, 1'b1, acc);
    send_cmd({10'd300, 10'd5}, {10'd301, 10'd6}, {10'd302, 10'd11}, 1'b1, 1'b1, acc);
    wait_idle(300);
    check("stale_done_starts", stale_seen, 2);
    check_drained("t5");
    lazy = 1'b0;

    // 6. asynchronous abort mid-RWAIT with two commands still queued
    start_frame(6'h01);
    send_cmd({10'd40, 10'd8}, {10'd41, 10'd9}, {10'd42, 10'd5}, 1'b0, 1'b1, acc);
    send_cmd({10'd50, 10'd8}, {10'd51, 10'd9}, {10'd52, 10'd6}, 1'b0, 1'b0, acc);
    send_cmd({10'd60, 10'd8}, {10'd61, 10'd9}, {10'd62, 10'd7}, 1'b1, 1'b0, acc);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rast_start) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_start_seen", found, 1'b1);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_fb_wen", fb_wen, 1'b0);
    check("abort_rast_reset", rast_reset, 1'b1);
    check("abort_rast_start", rast_start, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_cmd_ready", cmd_ready, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_drained("t6_abort");

    start_frame(6'h3E);
    repeat (NPIX + 20) @(negedge clk);
    check("post_abort_clear_done", exp_fb.size(), 0);
    check("post_abort_busy", busy, 1'b1);
    check("post_abort_fifo_empty_wait", rast_reset, 1'b1);
    check("post_abort_cmd_ready", cmd_ready, 1'b1);
    send_cmd({10'd70, 10'd8}, {10'd71, 10'd9}, {10'd72, 10'd12}, 1'b1, 1'b1, acc);
    wait_idle(100);
    check_drained("t6_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Per-frame controller for the triangle rasterizer.
- On each frame request it first clears the framebuffer to a background colour.
- It then feeds queued triangles to the rasterizer one at a time, holding the rasterizer in reset between triangles so its sticky done flag is re-armed.
- It owns the single framebuffer write port and muxes it between the internal clear engine and the rasterizer.

Parameters:
- H_RES, 640, horizontal resolution in pixels.
- V_RES, 480, vertical resolution in lines.
- ADDR_W, 19, framebuffer address width.
- COLOR_W, 6, pixel colour width.
- CMD_DEPTH, 4, triangle command FIFO depth (power of two).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle request to begin a frame.
- bg_color  in  COLOR_W  clear colour, sampled when frame_start is accepted.
- cmd_valid  in  1  triangle command valid.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_v0, cmd_v1, cmd_v2  in  20 each  vertices, {x[19:10], y[9:0]}.
- cmd_last  in  1  this triangle is the last of the frame.
- rast_reset  out  1  active-high synchronous reset to the rasterizer.
- rast_start  out  1  rasterizer start pulse.
- rast_done  in  1  rasterizer done; sticky until the rasterizer is reset.
- rast_v0, rast_v1, rast_v2  out  20 each  vertices driven to the rasterizer.
- rast_addr  in  ADDR_W  rasterizer write address.
- rast_dout  in  COLOR_W  rasterizer write data.
- rast_wen  in  1  rasterizer write enable.
- fb_addr  out  ADDR_W  framebuffer write address.
- fb_dout  out  COLOR_W  framebuffer write data.
- fb_wen  out  1  framebuffer write enable.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse at frame end.

Behaviour:
- Reset values (reset low, asynchronous):
  - state IDLE, FIFO empty, clear counter 0.
  - fb_wen 0, fb_addr 0, fb_dout 0.
  - rast_reset 1, rast_start 0, rast_v* 0.
  - frame_done 0, busy 0, cmd_ready 1.
- Command FIFO:
  - Push when cmd_valid and cmd_ready, in any state including IDLE and CLEAR.
  - cmd_ready = not full.
  - Each entry holds 61 bits (v0, v1, v2, last).
  - Pop and push in the same cycle are both allowed when full.
- rast_reset is 1 in every state except RSTART and RWAIT.
- States:
  - IDLE: frame_start=1 → latch bg_color, clear counter 0 → CLEAR. frame_start is ignored in all other states.
  - CLEAR: fb_wen=1, fb_addr=counter, fb_dout=latched colour; counter increments each cycle. When counter = H_RES*V_RES-1 (that write is issued) → FETCH. Duration is exactly H_RES*V_RES cycles.
  - FETCH: fb_wen=0. If FIFO not empty, pop, register vertices onto rast_v*, register last into last_q → RSTART. Otherwise wait. rast_reset is high for at least this one cycle.
  - RSTART: rast_reset=0, rast_start=1 for exactly one cycle → RWAIT.
  - RWAIT: fb_addr/fb_dout/fb_wen = rast_addr/rast_dout/rast_wen, combinational pass-through with zero latency. rast_done=1 → FDONE if last_q, else FETCH.
  - FDONE: frame_done=1 for one cycle → IDLE.
- rast_done is ignored outside RWAIT; it may still be stale-high during RSTART.
- fb_wen is forced 0 outside CLEAR and RWAIT, whatever rast_wen is.
- rast_v* hold their values from the FETCH pop until the next pop.
- Clear counter width is ADDR_W. The terminal compare uses the full product H_RES*V_RES, with no wrap-around.
- Asynchronous reset mid-frame aborts immediately. All queued commands are discarded and the rasterizer is held in reset.

Decomposition:
- Shared package gpu_pkg holds:
  - H_RES, V_RES, FB_PIXELS = H_RES*V_RES, ADDR_W, COLOR_W.
  - Vertex typedef {x[9:0], y[9:0]}.
  - State encoding IDLE/CLEAR/FETCH/RSTART/RWAIT/FDONE.
- One sub-module, cmd_fifo: synchronous FIFO, parameter WIDTH=61 and DEPTH=CMD_DEPTH, with full/empty flags and asynchronous active-low reset.

Test Plan:
Bench uses H_RES=8, V_RES=4 (32 pixels) and a rasterizer model that asserts done N cycles after start and stays high until reset.
1. Hold reset low, then release → fb_wen=0, rast_reset=1, rast_start=0, cmd_ready=1, busy=0, frame_done=0 throughout reset and in IDLE.
2. frame_start with bg_color=6'b000011 → exactly 32 consecutive fb_wen cycles, fb_addr 0..31, fb_dout 6'b000011; a second frame_start during CLEAR is ignored and busy=1.
3. One command (v0={230,200}, v1={400,450}, v2={170,400}, last=1), model N=10 emitting writes:
   - rast_v* match the command.
   - rast_start is a single cycle with rast_reset=0.
   - fb_* equal rast_* in the same cycle.
   - frame_done pulses the cycle after rast_done is first sampled, then IDLE.
4. Push 5 commands during CLEAR with CMD_DEPTH=4 → cmd_ready falls after the 4th push; the 5th is accepted only after the first FETCH pop.
5. Three commands with last on the third → three rast_start pulses; rast_reset high ≥1 cycle before each; exactly one frame_done; stale rast_done high during RSTART causes no early exit.
6. Assert reset mid-RWAIT with 2 commands queued → fb_wen=0 and rast_reset=1 immediately without waiting for a clock edge; FIFO empty; next frame_start restarts clearing from address 0.
